controle_sequenciador: RTL and testbench
========================================

Name: controle_sequenciador

Overview:
Moore FSM that sequences the 4-bit A/B arithmetic datapath through load A, load B, operate and display phases.
- Drives the one-hot register enables (habilita) and the phase code (estado).
- Latches the operation select (Funcao) once per computation.
- Holds the result on the 7-segment displays for a programmable number of cycles, then restarts.
- Sits between the top-level switches and the datapath/display blocks; consumes the datapath completion flags FimA, FimB, FimOp.

Parameters:
- HOLD_CYCLES, 8: cycles spent in EXIBE before returning to CARGA_A; legal range >= 1.
- OP_TIMEOUT, 16: maximum cycles spent in OPERA waiting for FimOp before flagging an error; legal range >= 2.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: reset, asynchronous, active-low (0 = reset).
- Funcao, input, 1: operation select from switch (0 = add, 1 = multiply); sampled only as defined below.
- FimA, input, 1: datapath done loading A; level, sampled on clk.
- FimB, input, 1: datapath done loading B; level, sampled on clk.
- FimOp, input, 1: datapath operation complete; level, sampled on clk.
- habilita, output, 3: one-hot enables; bit0 = reg A load, bit1 = reg B load, bit2 = operation/accumulator.
- estado, output, 2: current phase code.
- funcao_lat, output, 1: Funcao value latched for the current computation.
- exibe_en, output, 1: display-update enable for Hex0/Hex1.
- erro, output, 1: operation timeout flag.

Behaviour:
- Reset (rst = 0, async) forces every register immediately, no clock needed:
  - state = CARGA_A, so estado = 2'b00 and habilita = 3'b001.
  - funcao_lat = 0, exibe_en = 0, erro = 0, all counters = 0.
- All outputs are registered or decoded from the state register only; they change on the same edge as the state.
- States, transitions and outputs:
  - CARGA_A (00): habilita = 001. FimA = 1 moves to CARGA_B on the next edge.
  - CARGA_B (01): habilita = 010. FimB = 1 moves to OPERA. On that edge funcao_lat <= Funcao and the timeout counter <= 0.
  - OPERA (10): habilita = 100. Timeout counter increments every cycle.
    - FimOp = 1: go to EXIBE, hold counter <= HOLD_CYCLES-1, erro <= 0.
    - Otherwise, if the timeout counter == OP_TIMEOUT-1: go to EXIBE, hold counter <= HOLD_CYCLES-1, erro <= 1.
    - FimOp takes priority over timeout when both occur on the same cycle.
  - EXIBE (11): habilita = 000, exibe_en = 1. Hold counter decrements each cycle.
    - At count 0, go to CARGA_A on the next edge; erro <= 0 on that edge.
    - HOLD_CYCLES = 1 gives exactly one cycle in EXIBE.
- Flag handling:
  - Only the completion flag belonging to the current state is honoured; FimA/FimB/FimOp in any other state are ignored.
  - A flag held high continuously advances exactly one state per cycle.
  - Funcao changes outside the CARGA_B->OPERA edge have no effect on funcao_lat.
- Counter width: $clog2 of max(HOLD_CYCLES, OP_TIMEOUT), minimum 1. Counters do not wrap inside a state; they are reloaded on state entry.
- Reset asserted mid-operation (any state) aborts immediately to the reset values; no partial state is retained.
- Dwell times:
  - Minimum full loop with all flags high is 3 cycles plus HOLD_CYCLES.
  - Time-out case: OPERA occupies exactly OP_TIMEOUT cycles.

Optional Feature:
- Macro: RECALC_ON_FUNCAO_EN.
- Defined: in EXIBE, if Funcao != funcao_lat on a clock edge:
  - go back to OPERA, funcao_lat <= Funcao, timeout counter <= 0, erro <= 0.
  - This recomputes with the new operation without reloading A/B.
  - This check has priority over hold-counter expiry.
- Undefined: Funcao is ignored in EXIBE; behaviour is exactly as described above.

Test Plan:
1. Reset with rst = 0 at t = 0, released after 3 edges, all flags 0 -> estado = 00, habilita = 001, exibe_en = 0, erro = 0 throughout; asynchronous assertion mid-cycle clears outputs before the next edge.
2. Nominal loop, HOLD_CYCLES = 8, FimA/FimB/FimOp pulsed 1 cycle each in turn, Funcao = 1 -> estado sequence 00, 01, 10, 11, 11 for exactly 8 cycles in EXIBE, then 00; funcao_lat = 1; habilita 001/010/100/000.
3. Out-of-state flags: FimB and FimOp held high during CARGA_A -> state remains 00 until FimA; with all flags high continuously, one state per cycle (00, 01, 10, 11).
4. Timeout, OP_TIMEOUT = 16: FimOp never asserted -> exactly 16 cycles in OPERA, then EXIBE with erro = 1; erro = 0 after returning to CARGA_A. FimOp arriving on cycle 16 of OPERA -> erro stays 0.
5. Funcao toggles every cycle while in OPERA and EXIBE -> funcao_lat stays at the value sampled on the CARGA_B->OPERA edge (RECALC_ON_FUNCAO_EN undefined).
6. With RECALC_ON_FUNCAO_EN defined, Funcao flipped 0->1 on the 3rd EXIBE cycle -> next state OPERA, funcao_lat = 1, habilita = 100; after FimOp, a fresh 8-cycle EXIBE follows.

Source files
------------

// File: rtl/controle_sequenciador.sv
// Phase sequencer for the 4-bit A/B datapath: load A, load B, operate, display.
// Optional macro RECALC_ON_FUNCAO_EN: a Funcao change while displaying re-runs the operation.
module controle_sequenciador #(
  parameter int HOLD_CYCLES = 8,
  parameter int OP_TIMEOUT  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Funcao,
  input  logic       FimA,
  input  logic       FimB,
  input  logic       FimOp,
  output logic [2:0] habilita,
  output logic [1:0] estado,
  output logic       funcao_lat,
  output logic       exibe_en,
  output logic       erro
);

  localparam int MAXC = (HOLD_CYCLES > OP_TIMEOUT) ? HOLD_CYCLES : OP_TIMEOUT;
  localparam int CW   = ($clog2(MAXC) < 1) ? 1 : $clog2(MAXC);
  localparam logic [CW-1:0] HOLD_LOAD    = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(OP_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE      = CW'(1);

  typedef enum logic [1:0] {
    CARGA_A = 2'b00,
    CARGA_B = 2'b01,
    OPERA   = 2'b10,
    EXIBE   = 2'b11
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lat_q, lat_d;
  logic          erro_q, erro_d;
  logic [2:0]    hab_q, hab_d;
  logic          exibe_q, exibe_d;

  // One counter serves both phases: timeout count-up in OPERA, hold count-down in EXIBE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    erro_d  = erro_q;
    case (state_q)
      CARGA_A: begin
        if (FimA) state_d = CARGA_B;
      end
      CARGA_B: begin
        if (FimB) begin
          state_d = OPERA;
          lat_d   = Funcao;
          cnt_d   = '0;
        end
      end
      OPERA: begin
        if (FimOp) begin
          state_d = EXIBE;
          cnt_d   = HOLD_LOAD;
          erro_d  = 1'b0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = EXIBE;
          cnt_d   = HOLD_LOAD;
          erro_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      EXIBE: begin
        if (cnt_q == '0) begin
          state_d = CARGA_A;
          cnt_d   = '0;
          erro_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
`ifdef RECALC_ON_FUNCAO_EN
        // A new operation select overrides hold expiry and reuses the loaded operands.
        if (Funcao != lat_q) begin
          state_d = OPERA;
          lat_d   = Funcao;
          cnt_d   = '0;
          erro_d  = 1'b0;
        end
`endif
      end
      default: begin
        state_d = CARGA_A;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    hab_d   = 3'b000;
    exibe_d = 1'b0;
    case (state_d)
      CARGA_A: hab_d = 3'b001;
      CARGA_B: hab_d = 3'b010;
      OPERA:   hab_d = 3'b100;
      EXIBE:   exibe_d = 1'b1;
      default: hab_d = 3'b001;
    endcase
  end

  // Outputs are registered from the next state so they switch on the same edge as estado.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= CARGA_A;
      cnt_q   <= '0;
      lat_q   <= 1'b0;
      erro_q  <= 1'b0;
      hab_q   <= 3'b001;
      exibe_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      erro_q  <= erro_d;
      hab_q   <= hab_d;
      exibe_q <= exibe_d;
    end
  end

  assign estado     = state_q;
  assign habilita   = hab_q;
  assign funcao_lat = lat_q;
  assign exibe_en   = exibe_q;
  assign erro       = erro_q;

endmodule

// File: tb/tb_controle_sequenciador.sv
// Directed, table-driven bench for controle_sequenciador (default build, HOLD_CYCLES=8, OP_TIMEOUT=16).
module tb_controle_sequenciador;

  logic       clk;
  logic       rst;
  logic       Funcao, FimA, FimB, FimOp;
  logic [2:0] habilita;
  logic [1:0] estado;
  logic       funcao_lat, exibe_en, erro;

  int checks = 0;
  int errors = 0;

  controle_sequenciador #(.HOLD_CYCLES(8), .OP_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .Funcao(Funcao), .FimA(FimA), .FimB(FimB), .FimOp(FimOp),
    .habilita(habilita), .estado(estado), .funcao_lat(funcao_lat),
    .exibe_en(exibe_en), .erro(erro)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       f, a, b, op;
    logic [1:0] st;
    logic [2:0] hab;
    logic       lat, ex, er;
  } vec_t;

  vec_t vecs[36];

  function automatic vec_t mk(input logic f, a, b, op, input logic [1:0] st,
                              input logic [2:0] hab, input logic lat, ex, er);
    vec_t v;
    v.f = f; v.a = a; v.b = b; v.op = op;
    v.st = st; v.hab = hab; v.lat = lat; v.ex = ex; v.er = er;
    return v;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Drive inputs on the falling edge, then sample 1 time unit after the rising edge.
  task automatic applyStimulus(input logic f, a, b, op);
    @(negedge clk);
    Funcao = f; FimA = a; FimB = b; FimOp = op;
    @(posedge clk);
    #1;
  endtask

  task automatic checkAll(input string tag, input logic [1:0] st, input logic [2:0] hab,
                          input logic lat, ex, er);
    checkOutput({tag, ".estado"}, int'(estado), int'(st));
    checkOutput({tag, ".habilita"}, int'(habilita), int'(hab));
    checkOutput({tag, ".funcao_lat"}, int'(funcao_lat), int'(lat));
    checkOutput({tag, ".exibe_en"}, int'(exibe_en), int'(ex));
    checkOutput({tag, ".erro"}, int'(erro), int'(er));
  endtask

  initial begin
    int n;
    int m;

    // Nominal loop, out-of-state flags, flags held high, Funcao toggling in OPERA/EXIBE.
    vecs[0]  = mk(0,1,0,0, 2'd1, 3'b010, 0,0,0);
    vecs[1]  = mk(1,0,1,0, 2'd2, 3'b100, 1,0,0);
    vecs[2]  = mk(1,0,0,1, 2'd3, 3'b000, 1,1,0);
    for (int i = 3; i <= 9; i++) vecs[i] = mk(1,0,0,0, 2'd3, 3'b000, 1,1,0);
    vecs[10] = mk(1,0,0,0, 2'd0, 3'b001, 1,0,0);
    vecs[11] = mk(0,0,1,1, 2'd0, 3'b001, 1,0,0);
    vecs[12] = mk(0,0,1,1, 2'd0, 3'b001, 1,0,0);
    vecs[13] = mk(0,1,1,1, 2'd1, 3'b010, 1,0,0);
    vecs[14] = mk(0,1,1,1, 2'd2, 3'b100, 0,0,0);
    vecs[15] = mk(0,1,1,1, 2'd3, 3'b000, 0,1,0);
    for (int i = 16; i <= 22; i++) vecs[i] = mk(0,1,1,1, 2'd3, 3'b000, 0,1,0);
    vecs[23] = mk(0,1,1,1, 2'd0, 3'b001, 0,0,0);
    vecs[24] = mk(0,1,0,0, 2'd1, 3'b010, 0,0,0);
    vecs[25] = mk(1,0,1,0, 2'd2, 3'b100, 1,0,0);
    vecs[26] = mk(0,0,0,0, 2'd2, 3'b100, 1,0,0);
    vecs[27] = mk(1,0,0,1, 2'd3, 3'b000, 1,1,0);
    for (int i = 28; i <= 34; i++) vecs[i] = mk(logic'(i % 2 == 1),0,0,0, 2'd3, 3'b000, 1,1,0);
    vecs[35] = mk(0,0,0,0, 2'd0, 3'b001, 1,0,0);

    rst = 1'b0; Funcao = 1'b0; FimA = 1'b0; FimB = 1'b0; FimOp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkAll($sformatf("reset%0d", i), 2'd0, 3'b001, 1'b0, 1'b0, 1'b0);
    end
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 36; i++) begin
      applyStimulus(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].op);
      checkAll($sformatf("vec%0d", i), vecs[i].st, vecs[i].hab, vecs[i].lat, vecs[i].ex, vecs[i].er);
    end

    // Timeout: FimOp never arrives, OPERA must last exactly 16 cycles.
    applyStimulus(0,1,0,0);
    applyStimulus(0,0,1,0);
    checkOutput("to_enter_opera", int'(estado), 2);
    n = 1;
    for (int k = 0; k < 40 && estado == 2'd2; k++) begin
      applyStimulus(0,0,0,0);
      if (estado == 2'd2) n++;
    end
    checkOutput("to_opera_cycles", n, 16);
    checkAll("to_exibe", 2'd3, 3'b000, 1'b0, 1'b1, 1'b1);
    m = 1;
    for (int k = 0; k < 40 && estado == 2'd3; k++) begin
      applyStimulus(0,0,0,0);
      if (estado == 2'd3) m++;
    end
    checkOutput("to_exibe_cycles", m, 8);
    checkAll("to_back", 2'd0, 3'b001, 1'b0, 1'b0, 1'b0);

    // FimOp on the 16th OPERA cycle wins over the timeout.
    applyStimulus(0,1,0,0);
    applyStimulus(1,0,1,0);
    for (int k = 0; k < 15; k++) applyStimulus(0,0,0,0);
    checkOutput("late_still_opera", int'(estado), 2);
    applyStimulus(0,0,0,1);
    checkAll("late_fimop", 2'd3, 3'b000, 1'b1, 1'b1, 1'b0);

    // Asynchronous reset mid-EXIBE clears everything before the next edge.
    applyStimulus(0,0,0,0);
    #2;
    rst = 1'b0;
    #1;
    checkAll("async_rst", 2'd0, 3'b001, 1'b0, 1'b0, 1'b0);
    applyStimulus(0,1,0,0);
    checkAll("rst_held", 2'd0, 3'b001, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(0,1,0,0);
    checkAll("post_rst", 2'd1, 3'b010, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
